// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, error-flag bit positions,
// character-length encoding and the FIFO entry layout.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } rx_state_t;

    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [2:0] last_data_idx(input logic [1:0] db);
        return {1'b0, db} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_v2_if.sv
// Receive-FIFO read port and status bundle; master is the receiver, slave the consumer.
// Status outputs are level signals; fifo_rd is a one-cycle pop request.
interface uart_rx_v2_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_rd;
    logic [CW-1:0] rx_thresh;
    logic          overrun_clr;
    logic [7:0]    fifo_data_out;
    logic [2:0]    fifo_err_out;
    logic          rxff;
    logic          rxfe;
    logic [CW-1:0] rx_count;
    logic          rx_overrun;
    logic          rx_thresh_hit;
    logic          rx_timeout;

    modport master (
        input  fifo_rd, rx_thresh, overrun_clr,
        output fifo_data_out, fifo_err_out, rxff, rxfe, rx_count,
               rx_overrun, rx_thresh_hit, rx_timeout
    );

    modport slave (
        output fifo_rd, rx_thresh, overrun_clr,
        input  fifo_data_out, fifo_err_out, rxff, rxfe, rx_count,
               rx_overrun, rx_thresh_hit, rx_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head valid the cycle after a push into an empty FIFO.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Gate the head so an empty FIFO never exposes stale or uninitialised storage.
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/uart_rx_v2.sv
// Oversampling UART receiver with FWFT receive FIFO; entry pushed one cycle after the last stop sample.
// No backpressure on the line: a push into a full FIFO is dropped and sets rx_overrun. Timeout via UART_RX_TIMEOUT_EN.
module uart_rx_v2
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_divisor,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop_bits,
    input  logic             rx_in,
    uart_rx_v2_if.master     host
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0]    SMP_ONE  = 1;
    localparam logic [SW-1:0]    SMP_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]    SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;

    logic rx_s1, rx_s;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s  <= rx_s1;
        end
    end

    rx_state_t  state;
    logic       start_go;
    logic       tick;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;

    assign start_go = (state == ST_IDLE) && !rx_s;
    assign div_last = (baud_divisor == '0) ? '0 : baud_divisor - DIV_ONE;
    assign tick     = (div_cnt >= div_last);

    always_ff @(posedge clk) begin
        if (reset || start_go || tick) div_cnt <= '0;
        else                           div_cnt <= div_cnt + DIV_ONE;
    end

    logic [SW-1:0] smp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          frm_err;
    logic [1:0]    db_r;
    logic          par_en_r, par_odd_r, two_stop_r;
    logic          push_vld;
    rx_entry_t     push_dat;
    rx_entry_t     entry_nxt;
    logic          smp_hit;
    logic          par_err;
    logic          brk_det;

    assign smp_hit = tick && (smp_cnt == ((state == ST_START) ? SMP_HALF : SMP_LAST));
    assign par_err = par_en_r && (((^shreg) ^ par_bit) != par_odd_r);
    assign brk_det = (shreg == '0) && !(par_en_r && par_bit) && !rx_s;

    always_comb begin
        entry_nxt              = '0;
        entry_nxt.data         = shreg;
        entry_nxt.err[ERR_PAR] = par_err;
        entry_nxt.err[ERR_FRM] = frm_err || !rx_s;
        entry_nxt.err[ERR_BRK] = (state == ST_STOP1) && brk_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            smp_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            frm_err    <= 1'b0;
            db_r       <= DB_8;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            two_stop_r <= 1'b0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
        end else begin
            push_vld <= 1'b0;
            if (state != ST_IDLE && state != ST_BRK_WAIT && tick)
                smp_cnt <= smp_hit ? '0 : smp_cnt + SMP_ONE;
            case (state)
                ST_IDLE: if (start_go) begin
                    // Frame format is frozen here for the whole character.
                    state      <= ST_START;
                    smp_cnt    <= '0;
                    bit_idx    <= '0;
                    shreg      <= '0;
                    par_bit    <= 1'b0;
                    frm_err    <= 1'b0;
                    db_r       <= data_bits;
                    par_en_r   <= parity_en;
                    par_odd_r  <= parity_odd;
                    two_stop_r <= two_stop_bits;
                end
                ST_START: if (smp_hit) state <= rx_s ? ST_IDLE : ST_DATA;
                ST_DATA: if (smp_hit) begin
                    shreg[bit_idx] <= rx_s;
                    bit_idx        <= bit_idx + 3'd1;
                    if (bit_idx == last_data_idx(db_r))
                        state <= par_en_r ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: if (smp_hit) begin
                    par_bit <= rx_s;
                    state   <= ST_STOP1;
                end
                ST_STOP1: if (smp_hit) begin
                    if (brk_det) begin
                        push_vld <= 1'b1;
                        push_dat <= entry_nxt;
                        state    <= ST_BRK_WAIT;
                    end else if (two_stop_r) begin
                        frm_err <= !rx_s;
                        state   <= ST_STOP2;
                    end else begin
                        push_vld <= 1'b1;
                        push_dat <= entry_nxt;
                        state    <= ST_IDLE;
                    end
                end
                ST_STOP2: if (smp_hit) begin
                    push_vld <= 1'b1;
                    push_dat <= entry_nxt;
                    state    <= ST_IDLE;
                end
                ST_BRK_WAIT: if (rx_s) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    rx_entry_t     head;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (host.fifo_rd),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop),
        .count    (fifo_count)
    );

    logic overrun_q;
    always_ff @(posedge clk) begin
        if (reset)                 overrun_q <= 1'b0;
        else if (fifo_drop)        overrun_q <= 1'b1;
        else if (host.overrun_clr) overrun_q <= 1'b0;
    end

    logic timeout;
`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_TICKS = 40 * OVERSAMPLE;
    localparam int TW       = $clog2(TO_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS - 1);
    localparam logic [TW-1:0] TO_ONE  = 1;

    logic [TW-1:0] to_cnt;
    logic          timeout_q;
    always_ff @(posedge clk) begin
        if (reset || state != ST_IDLE || fifo_empty || host.fifo_rd) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (tick && !timeout_q) begin
            if (to_cnt == TO_LAST) timeout_q <= 1'b1;
            else                   to_cnt    <= to_cnt + TO_ONE;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign host.fifo_data_out = head.data;
    assign host.fifo_err_out  = head.err;
    assign host.rxff          = fifo_full;
    assign host.rxfe          = fifo_empty;
    assign host.rx_count      = fifo_count;
    assign host.rx_overrun    = overrun_q;
    assign host.rx_thresh_hit = (host.rx_thresh != '0) && (fifo_count >= host.rx_thresh);
    assign host.rx_timeout    = timeout;
endmodule
